// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, FSM state codes, datapath mux codes.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package mips_pkg;

  localparam int STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // All per-cycle datapath controls, bundled so the decode has one default.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  // True for the opcodes this control FSM knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the main control FSM and the multicycle datapath.
// Latency: none (wires only).
// Backpressure: none; controls are asserted every cycle with no handshake.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic       RegDst;
  logic       illegal_op;
  logic       instr_done;
  logic [3:0] state;

  // Controller side: reads the opcode, drives every control.
  modport master (
    input  opcode,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
           illegal_op, instr_done, state
  );

  // Datapath side: supplies the opcode, consumes the controls.
  modport slave (
    output opcode,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
           illegal_op, instr_done, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS CPU (fetch/decode/execute/mem/writeback sequencing).
// Latency: lw 5, sw/R/addi 4, beq/j 3, illegal 2 cycles from FETCH; controls decode from current state.
// Backpressure: none; memory is single-cycle and the FSM never stalls.
module multicycle_control
  import mips_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // State register; reset aborts any instruction in flight and restarts at FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing; opcode only matters in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXEC:    state_d = S_RTYPE_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode from state; everything is held low while reset is asserted.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = ALUSRCB_IMM_SH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = ~op_supported(bus.opcode);
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
    if (rst) begin
      ctrl = '0;
    end
  end

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.illegal_op  = ctrl.illegal_op;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and full control-word checks.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: none; fixed cycle counts, no open-ended waits.
module tb_multicycle_control;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  multicycle_control_if bus_if ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word order:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite}_{PCSource}_{ALUOp}_{ALUSrcA}_{ALUSrcB}_{RegWrite,RegDst,illegal_op,instr_done}
  localparam logic [17:0] CW_ZERO    = 18'b0000000_00_00_0_00_0000;
  localparam logic [17:0] CW_FETCH   = 18'b1001001_00_00_0_01_0000;
  localparam logic [17:0] CW_DECODE  = 18'b0000000_00_00_0_11_0000;
  localparam logic [17:0] CW_DEC_ILL = 18'b0000000_00_00_0_11_0010;
  localparam logic [17:0] CW_MEMADR  = 18'b0000000_00_00_1_10_0000;
  localparam logic [17:0] CW_MEMRD   = 18'b0011000_00_00_0_00_0000;
  localparam logic [17:0] CW_MEMWB   = 18'b0000010_00_00_0_00_1001;
  localparam logic [17:0] CW_MEMWR   = 18'b0010100_00_00_0_00_0001;
  localparam logic [17:0] CW_EXEC    = 18'b0000000_00_10_1_00_0000;
  localparam logic [17:0] CW_RWB     = 18'b0000000_00_00_0_00_1101;
  localparam logic [17:0] CW_BRANCH  = 18'b0100000_01_01_1_00_0001;
  localparam logic [17:0] CW_JUMP    = 18'b1000000_10_00_0_00_0001;
  localparam logic [17:0] CW_ADDI_EX = 18'b0000000_00_00_1_10_0000;
  localparam logic [17:0] CW_ADDI_WB = 18'b0000000_00_00_0_00_1001;

  function automatic logic [17:0] cw_now();
    return {bus_if.PCWrite, bus_if.PCWriteCond, bus_if.IorD, bus_if.MemRead,
            bus_if.MemWrite, bus_if.MemtoReg, bus_if.IRWrite, bus_if.PCSource,
            bus_if.ALUOp, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.RegWrite,
            bus_if.RegDst, bus_if.illegal_op, bus_if.instr_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check state and control word in the current cycle, then advance one cycle.
  task automatic step(input string tag, input logic [3:0] exp_state, input logic [17:0] exp_cw);
    check({tag, ".state"}, {28'd0, bus_if.state}, {28'd0, exp_state});
    check({tag, ".cw"}, {14'd0, cw_now()}, {14'd0, exp_cw});
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus_if.opcode = 6'h00;

    // Reset held for three clocks: everything quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst%0d.state", i), {28'd0, bus_if.state}, 32'd0);
      check($sformatf("rst%0d.cw", i), {14'd0, cw_now()}, {14'd0, CW_ZERO});
    end
    rst = 1'b0;
    #1;

    // lw: 0,1,2,3,4 then back to FETCH.
    bus_if.opcode = 6'h23;
    step("lw0", 4'd0, CW_FETCH);
    step("lw1", 4'd1, CW_DECODE);
    step("lw2", 4'd2, CW_MEMADR);
    step("lw3", 4'd3, CW_MEMRD);
    step("lw4", 4'd4, CW_MEMWB);

    // sw: 0,1,2,5.
    bus_if.opcode = 6'h2B;
    step("sw0", 4'd0, CW_FETCH);
    step("sw1", 4'd1, CW_DECODE);
    step("sw2", 4'd2, CW_MEMADR);
    step("sw5", 4'd5, CW_MEMWR);

    // R-type, beq, j back-to-back.
    bus_if.opcode = 6'h00;
    step("r0", 4'd0, CW_FETCH);
    step("r1", 4'd1, CW_DECODE);
    step("r6", 4'd6, CW_EXEC);
    step("r7", 4'd7, CW_RWB);
    bus_if.opcode = 6'h04;
    step("beq0", 4'd0, CW_FETCH);
    step("beq1", 4'd1, CW_DECODE);
    step("beq8", 4'd8, CW_BRANCH);
    bus_if.opcode = 6'h02;
    step("j0", 4'd0, CW_FETCH);
    step("j1", 4'd1, CW_DECODE);
    step("j9", 4'd9, CW_JUMP);

    // addi: 0,1,10,11.
    bus_if.opcode = 6'h08;
    step("addi0", 4'd0, CW_FETCH);
    step("addi1", 4'd1, CW_DECODE);
    step("addi10", 4'd10, CW_ADDI_EX);
    step("addi11", 4'd11, CW_ADDI_WB);

    // Illegal opcode: 0,1 (illegal_op pulse), then FETCH with no pulse.
    bus_if.opcode = 6'h3F;
    step("ill0", 4'd0, CW_FETCH);
    step("ill1", 4'd1, CW_DEC_ILL);
    step("ill_back", 4'd0, CW_FETCH);
    step("ill_dec2", 4'd1, CW_DEC_ILL);

    // lw aborted by an asynchronous reset pulse during MEMRD.
    bus_if.opcode = 6'h23;
    step("ab0", 4'd0, CW_FETCH);
    step("ab1", 4'd1, CW_DECODE);
    step("ab2", 4'd2, CW_MEMADR);
    check("ab3.state", {28'd0, bus_if.state}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("ab_rst.state", {28'd0, bus_if.state}, 32'd0);
    check("ab_rst.cw", {14'd0, cw_now()}, {14'd0, CW_ZERO});
    @(negedge clk);
    check("ab_hold.state", {28'd0, bus_if.state}, 32'd0);
    check("ab_hold.regwrite", {31'd0, bus_if.RegWrite}, 32'd0);
    rst = 1'b0;
    #1;
    step("ab_f", 4'd0, CW_FETCH);
    step("ab_d", 4'd1, CW_DECODE);
    step("ab_m", 4'd2, CW_MEMADR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
